ctrl_sequencer: RTL and testbench

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

---
 rtl/ctrl_sequencer.sv | 143 ++++++++++++++
 tb/tb_ctrl_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: instruction FIFO feeding a two-beat control sequencer.
// Each instruction is issued as beat A ({op, waddr, sh}, phi1_en) then
// beat B ({op, baddr, aaddr}, phi2_en). If the next instruction reads the
// register written by the previously issued one, a single NOP bubble pair
// is inserted before it.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   instruction push handshake
//   in_instr[10:0]      op[10:8] waddr[7:6] baddr[5:4] aaddr[3:2] sh[1:0]
//   ctrl[6:0]           registered control word
//   phi1_en / phi2_en   ctrl holds a beat-A / beat-B word
//   busy                sequencer active or instructions queued
//   stall_cnt[7:0]      saturating count of inserted bubbles
module ctrl_sequencer #(
  parameter int         DEPTH  = 4,
  parameter logic [2:0] NOP_OP = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] in_instr,
  output logic [6:0]  ctrl,
  output logic        phi1_en,
  output logic        phi2_en,
  output logic        busy,
  output logic [7:0]  stall_cnt
);
  localparam int         PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE  = (PW+1)'(1);

  typedef enum logic [2:0] {IDLE, BEAT_A, BEAT_B, BUB_A, BUB_B} state_t;
  state_t state;

  logic [10:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, cand_idx;
  logic [PW:0]   count;
  logic          push, pop;
  logic [10:0]   cand;
  logic          cand_avail, hazard;
  logic          last_wr_valid;
  logic [1:0]    last_waddr;

  assign in_ready = (count < FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == BEAT_B);
  assign busy     = (state != IDLE) || (count != '0);

  // The instruction that would issue next. In BEAT_B the head is being
  // popped on this edge, so look one entry past it; elsewhere it is the head.
  assign cand_idx   = (state == BEAT_B) ? rd_ptr + 1'b1 : rd_ptr;
  assign cand       = mem[cand_idx];
  assign cand_avail = (state == BEAT_B) ? (count > ONE) : (count != '0);
  assign hazard     = last_wr_valid &&
                      ((cand[5:4] == last_waddr) || (cand[3:2] == last_waddr));

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ctrl          <= '0;
      phi1_en       <= 1'b0;
      phi2_en       <= 1'b0;
      last_wr_valid <= 1'b0;
      last_waddr    <= '0;
      stall_cnt     <= '0;
    end else begin
      case (state)
        IDLE, BEAT_B: begin
          if (!cand_avail) begin
            state   <= IDLE;
            ctrl    <= '0;
            phi1_en <= 1'b0;
            phi2_en <= 1'b0;
          end else if (hazard) begin
            // Clearing last_wr_valid guarantees the instruction issues
            // right after this one bubble pair.
            state         <= BUB_A;
            ctrl          <= {NOP_OP, 4'b0000};
            phi1_en       <= 1'b1;
            phi2_en       <= 1'b0;
            last_wr_valid <= 1'b0;
            if (stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
          end else begin
            state         <= BEAT_A;
            ctrl          <= {cand[10:8], cand[7:6], cand[1:0]};
            phi1_en       <= 1'b1;
            phi2_en       <= 1'b0;
            last_wr_valid <= (cand[10:8] != NOP_OP);
            last_waddr    <= cand[7:6];
          end
        end
        BEAT_A: begin
          state   <= BEAT_B;
          ctrl    <= {cand[10:8], cand[5:4], cand[3:2]};
          phi1_en <= 1'b0;
          phi2_en <= 1'b1;
        end
        BUB_A: begin
          state   <= BUB_B;
          ctrl    <= {NOP_OP, 4'b0000};
          phi1_en <= 1'b0;
          phi2_en <= 1'b1;
        end
        BUB_B: begin
          // cand is the (unpopped) head here
          state         <= BEAT_A;
          ctrl          <= {cand[10:8], cand[7:6], cand[1:0]};
          phi1_en       <= 1'b1;
          phi2_en       <= 1'b0;
          last_wr_valid <= (cand[10:8] != NOP_OP);
          last_waddr    <= cand[7:6];
        end
        default: begin
          state   <= IDLE;
          ctrl    <= '0;
          phi1_en <= 1'b0;
          phi2_en <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Testbench for ctrl_sequencer: scoreboard of expected {phi1,phi2,ctrl}
// words queued at instruction acceptance and compared as beats appear.
module tb_ctrl_sequencer;
  localparam logic [2:0] NOP = 3'b000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [10:0] in_instr = '0;
  logic        in_ready;
  logic [6:0]  ctrl;
  logic        phi1_en, phi2_en, busy;
  logic [7:0]  stall_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          act_cnt = 0;
  logic [8:0]  sb_q[$];
  logic [8:0]  sb_e;
  logic        m_lv = 1'b0;
  logic [1:0]  m_lw = '0;
  int          m_stall = 0;

  logic [6:0]  exp_rdy;
  int          exp_acc[7] = '{1, 2, 3, 4, 4, 4, 5};

  ctrl_sequencer #(.DEPTH(4), .NOP_OP(NOP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .ctrl(ctrl), .phi1_en(phi1_en), .phi2_en(phi2_en),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected issue words for one accepted instruction
  task automatic sb_issue(input logic [10:0] i);
    logic hz;
    hz = m_lv && ((i[5:4] == m_lw) || (i[3:2] == m_lw));
    if (hz) begin
      sb_q.push_back({2'b10, NOP, 4'b0000});
      sb_q.push_back({2'b01, NOP, 4'b0000});
      m_lv = 1'b0;
      if (m_stall < 255) m_stall++;
    end
    sb_q.push_back({2'b10, i[10:8], i[7:6], i[1:0]});
    sb_q.push_back({2'b01, i[10:8], i[5:4], i[3:2]});
    m_lv = (i[10:8] != NOP);
    m_lw = i[7:6];
  endtask

  task automatic push(input logic [10:0] i);
    logic acc;
    int g;
    g = 0;
    in_valid = 1'b1;
    in_instr = i;
    do begin
      acc = in_ready;
      tick();
      g++;
    end while (!acc && g < 200);
    in_valid = 1'b0;
    if (acc) sb_issue(i);
    else chk("push_timeout", 32'(acc), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    sb_q.delete();
    m_lv = 1'b0;
    m_lw = '0;
    m_stall = 0;
    rst = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((busy || sb_q.size() != 0) && g < 3000) begin
      tick();
      g++;
    end
    chk("drain", 32'(g < 3000), 1);
  endtask

  // beat monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (phi1_en || phi2_en) begin
        act_cnt++;
        if (sb_q.size() == 0)
          chk("sb_unexpected", 32'({phi1_en, phi2_en, ctrl}), 0);
        else begin
          sb_e = sb_q.pop_front();
          chk("sb_word", 32'({phi1_en, phi2_en, ctrl}), 32'(sb_e));
        end
      end else
        chk("idle_ctrl", 32'(ctrl), 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running");
    $fatal(1);
  end

  initial begin
    int a0, acc_n;
    logic acc;
    exp_rdy = 7'b0100111;

    // reset state
    tick();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ctrl", 32'(ctrl), 0);
    chk("rst_phi1", 32'(phi1_en), 0);
    chk("rst_phi2", 32'(phi2_en), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    do_reset();

    // single instruction, latency and beat words
    push(11'h5E4);
    chk("lat_edge_n", 32'(phi1_en), 0);
    tick();
    chk("lat_beat_a", 32'(phi1_en), 1);
    chk("beat_a_ctrl", 32'(ctrl), 32'h5C);
    tick();
    chk("beat_b_phi2", 32'(phi2_en), 1);
    chk("beat_b_ctrl", 32'(ctrl), 32'h59);
    tick();
    chk("single_busy", 32'(busy), 0);
    chk("single_phi1", 32'(phi1_en), 0);
    drain();

    // RAW hazard: writer of r2 then reader aaddr=2
    do_reset();
    push(11'h181);
    push(11'h248);
    drain();
    chk("hazard_stall", 32'(stall_cnt), 1);

    // NOP producer does not create a hazard
    do_reset();
    push(11'h040);
    push(11'h284);
    drain();
    chk("nop_stall", 32'(stall_cnt), 0);

    // fill: every instruction hazards, so the first pop is late
    do_reset();
    push(11'h140);
    drain();
    in_valid = 1'b1;
    in_instr = 11'h144;
    acc_n = 0;
    for (int k = 0; k < 7; k++) begin
      acc = in_ready;
      tick();
      if (acc) begin
        acc_n++;
        sb_issue(11'h144);
      end
      if (acc_n == 5) in_valid = 1'b0;
      chk($sformatf("fill_rdy_%0d", k + 1), 32'(in_ready), 32'(exp_rdy[k]));
      chk($sformatf("fill_acc_%0d", k + 1), 32'(acc_n), 32'(exp_acc[k]));
    end
    in_valid = 1'b0;
    drain();
    chk("fill_stall", 32'(stall_cnt), 5);

    // throughput: hazard-free stream issues every 2 cycles, no gaps
    do_reset();
    in_instr = 11'h3D2;
    for (int k = 1; k <= 10; k++) begin
      in_valid = (k <= 4);
      acc = in_valid && in_ready;
      tick();
      if (acc) sb_issue(11'h3D2);
      chk($sformatf("tput_act_%0d", k), 32'(phi1_en || phi2_en), 32'(k >= 2 && k <= 9));
      chk($sformatf("tput_phi1_%0d", k), 32'(phi1_en), 32'(k >= 2 && k <= 9 && (k % 2) == 0));
    end
    in_valid = 1'b0;
    drain();

    // reset during BEAT_B with instructions queued
    do_reset();
    for (int k = 0; k < 4; k++) push(11'h3D2);
    a0 = 0;
    while (!phi2_en && a0 < 20) begin
      tick();
      a0++;
    end
    chk("rst_mid_wait_b", 32'(phi2_en), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", 32'(ctrl), 0);
    chk("rst_mid_phi1", 32'(phi1_en), 0);
    chk("rst_mid_phi2", 32'(phi2_en), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_ready", 32'(in_ready), 1);
    sb_q.delete();
    m_lv = 1'b0;
    m_lw = '0;
    m_stall = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    a0 = act_cnt;
    repeat (10) tick();
    chk("rst_mid_quiet", 32'(act_cnt - a0), 0);
    chk("rst_mid_busy2", 32'(busy), 0);

    // stall counter saturation: 300 hazarded instructions
    do_reset();
    for (int k = 0; k < 301; k++) push(11'h155);
    drain();
    chk("stall_sat", 32'(stall_cnt), 255);
    chk("stall_model", 32'(stall_cnt), 32'(m_stall));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
